// File: rtl/shift_pkg.sv
// Shared shifter op encodings and default widths for the shift arbiter slice.
package shift_pkg;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRA = 2'b01;
   localparam logic [1:0] SH_SRL = 2'b10;
   localparam logic [1:0] SH_BAD = 2'b11;

   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_SHAMT_W = 5;

endpackage

// File: rtl/shifter.sv
// Combinational barrel shifter: SLL/SRA/SRL; the illegal encoding yields zero.
module shifter
   import shift_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
   input  logic [DATA_W-1:0]  operand,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         ctrl,
   output logic [DATA_W-1:0]  result
);

   always_comb begin
      result = '0;
      case (ctrl)
         SH_SLL:  result = operand << shamt;
         SH_SRA:  result = $signed(operand) >>> shamt;
         SH_SRL:  result = operand >> shamt;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester valid/ready arbiter in front of one shared shifter, with a
// one-entry registered response slot tagged by the winning requester.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned SHAMT_W = DEF_SHAMT_W,
   parameter bit          RR_EN   = 1'b1
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               r0_valid,
   output logic               r0_ready,
   input  logic [DATA_W-1:0]  r0_data,
   input  logic [SHAMT_W-1:0] r0_shamt,
   input  logic [1:0]         r0_ctrl,

   input  logic               r1_valid,
   output logic               r1_ready,
   input  logic [DATA_W-1:0]  r1_data,
   input  logic [SHAMT_W-1:0] r1_shamt,
   input  logic [1:0]         r1_ctrl,

   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_id,
   output logic               rsp_err
);

   logic               last_gnt;
   logic               gnt;
   logic               slot_free;
   logic               accept;
   logic [DATA_W-1:0]  sh_operand;
   logic [SHAMT_W-1:0] sh_shamt;
   logic [1:0]         sh_ctrl;
   logic [DATA_W-1:0]  sh_result;

   always_comb begin
      gnt = 1'b0;
      if (r0_valid && r1_valid) begin
         gnt = RR_EN ? ~last_gnt : 1'b0;
      end else if (r1_valid) begin
         gnt = 1'b1;
      end
   end

   // Readies are forced low during reset so no op is consumed in that cycle.
   assign slot_free = ~rsp_valid | rsp_ready;
   assign r0_ready  = ~rst & slot_free & r0_valid & ~gnt;
   assign r1_ready  = ~rst & slot_free & r1_valid & gnt;
   assign accept    = r0_ready | r1_ready;

   assign sh_operand = gnt ? r1_data  : r0_data;
   assign sh_shamt   = gnt ? r1_shamt : r0_shamt;
   assign sh_ctrl    = gnt ? r1_ctrl  : r0_ctrl;

   shifter #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .operand (sh_operand),
      .shamt   (sh_shamt),
      .ctrl    (sh_ctrl),
      .result  (sh_result)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= 1'b0;
         rsp_err   <= 1'b0;
         last_gnt  <= 1'b1;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_data  <= sh_result;
         rsp_id    <= gnt;
         rsp_err   <= (sh_ctrl == SH_BAD);
         last_gnt  <= gnt;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized
// run against an arithmetic reference model.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r1_valid, rsp_ready;
   logic [31:0] r0_data, r1_data;
   logic [4:0]  r0_shamt, r1_shamt;
   logic [1:0]  r0_ctrl, r1_ctrl;

   logic        rr_r0_ready, rr_r1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_err;
   logic [31:0] rr_rsp_data;
   logic        fp_r0_ready, fp_r1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err;
   logic [31:0] fp_rsp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk       (clk),
      .rst       (rst),
      .r0_valid  (r0_valid),
      .r0_ready  (rr_r0_ready),
      .r0_data   (r0_data),
      .r0_shamt  (r0_shamt),
      .r0_ctrl   (r0_ctrl),
      .r1_valid  (r1_valid),
      .r1_ready  (rr_r1_ready),
      .r1_data   (r1_data),
      .r1_shamt  (r1_shamt),
      .r1_ctrl   (r1_ctrl),
      .rsp_valid (rr_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rr_rsp_data),
      .rsp_id    (rr_rsp_id),
      .rsp_err   (rr_rsp_err)
   );

   shift_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk       (clk),
      .rst       (rst),
      .r0_valid  (r0_valid),
      .r0_ready  (fp_r0_ready),
      .r0_data   (r0_data),
      .r0_shamt  (r0_shamt),
      .r0_ctrl   (r0_ctrl),
      .r1_valid  (r1_valid),
      .r1_ready  (fp_r1_ready),
      .r1_data   (r1_data),
      .r1_shamt  (r1_shamt),
      .r1_ctrl   (r1_ctrl),
      .rsp_valid (fp_rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (fp_rsp_data),
      .rsp_id    (fp_rsp_id),
      .rsp_err   (fp_rsp_err)
   );

   // Shift expressed as multiply / floor-divide by a power of two.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                             input logic [1:0] c);
      longint p;
      longint dz;
      longint sx;
      longint q;
      p  = 1;
      for (int k = 0; k < s; k++) p = p * 2;
      dz = longint'(d);
      sx = longint'($signed(d));
      q  = 0;
      case (c)
         2'd0: q = (dz * p) % 64'h1_0000_0000;
         2'd1: begin
            q = sx / p;
            if (sx < 0 && (sx % p) != 0) q = q - 1;
         end
         2'd2: q = dz / p;
         default: q = 0;
      endcase
      return q[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      r0_valid = 1'b0; r0_data = '0; r0_shamt = '0; r0_ctrl = 2'b00;
      r1_valid = 1'b0; r1_data = '0; r1_shamt = '0; r1_ctrl = 2'b00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      rsp_ready = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({rr_r0_ready, rr_r1_ready, fp_r0_ready, fp_r1_ready} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ready got=%b%b%b%b want=0000", rr_r0_ready, rr_r1_ready,
                  fp_r0_ready, fp_r1_ready);
      end
      checks++;
      if ({rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_data} !== 35'd0 || fp_rsp_valid !== 1'b0)
      begin
         errors++;
         $display("FAIL reset_state got v=%b id=%b err=%b data=%h fpv=%b want all 0",
                  rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_data, fp_rsp_valid);
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   task automatic test_sll();
      do_reset();
      r0_valid = 1'b1; r0_data = 32'h0000_00F0; r0_shamt = 5'd4; r0_ctrl = 2'b00;
      #1;
      checks++;
      if (rr_r0_ready !== 1'b1 || rr_r1_ready !== 1'b0) begin
         errors++;
         $display("FAIL sll_ready got r0=%b r1=%b want r0=1 r1=0", rr_r0_ready, rr_r1_ready);
      end
      tick();
      r0_valid = 1'b0;
      checks++;
      if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'h0000_0F00 || rr_rsp_id !== 1'b0 ||
          rr_rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL sll_rsp got v=%b data=%h id=%b err=%b want v=1 data=00000f00 id=0 err=0",
                  rr_rsp_valid, rr_rsp_data, rr_rsp_id, rr_rsp_err);
      end
   endtask

   task automatic test_sra_srl();
      do_reset();
      r1_valid = 1'b1; r1_data = 32'h8000_0000; r1_shamt = 5'd31; r1_ctrl = 2'b01;
      tick();
      checks++;
      if (rr_rsp_data !== 32'hFFFF_FFFF || rr_rsp_id !== 1'b1 || rr_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL sra_fill got data=%h id=%b v=%b want data=ffffffff id=1 v=1",
                  rr_rsp_data, rr_rsp_id, rr_rsp_valid);
      end
      r1_ctrl = 2'b10;
      tick();
      r1_valid = 1'b0;
      checks++;
      if (rr_rsp_data !== 32'h0000_0001 || rr_rsp_id !== 1'b1) begin
         errors++;
         $display("FAIL srl_zero got data=%h id=%b want data=00000001 id=1", rr_rsp_data,
                  rr_rsp_id);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      r0_valid = 1'b1; r0_data = 32'h1; r0_shamt = 5'd1; r0_ctrl = 2'b00;
      r1_valid = 1'b1; r1_data = 32'h10; r1_shamt = 5'd1; r1_ctrl = 2'b10;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (rr_r0_ready !== ((i % 2) == 0) || rr_r1_ready !== ((i % 2) == 1)) begin
            errors++;
            $display("FAIL rr_grant[%0d] got r0=%b r1=%b want r0=%0d r1=%0d", i, rr_r0_ready,
                     rr_r1_ready, (i % 2) == 0, (i % 2) == 1);
         end
         checks++;
         if (fp_r0_ready !== 1'b1 || fp_r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL fp_grant[%0d] got r0=%b r1=%b want r0=1 r1=0", i, fp_r0_ready,
                     fp_r1_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (rr_rsp_id !== 1'((i % 2)) || rr_rsp_data !== ((i % 2) ? 32'h8 : 32'h2)) begin
            errors++;
            $display("FAIL rr_id[%0d] got id=%b data=%h want id=%0d", i, rr_rsp_id, rr_rsp_data,
                     i % 2);
         end
         checks++;
         if (fp_rsp_id !== 1'b0 || fp_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL fp_id[%0d] got id=%b v=%b want id=0 v=1", i, fp_rsp_id, fp_rsp_valid);
         end
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      r0_valid = 1'b1; r0_data = 32'd3; r0_shamt = 5'd1; r0_ctrl = 2'b00;
      tick();
      r0_data = 32'd5; r0_shamt = 5'd2;
      r1_valid = 1'b1; r1_data = 32'd7; r1_shamt = 5'd0; r1_ctrl = 2'b10;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (rr_r0_ready !== 1'b0 || rr_r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready[%0d] got r0=%b r1=%b want 0 0", i, rr_r0_ready, rr_r1_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd6 || rr_rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] got v=%b data=%h id=%b want v=1 data=6 id=0", i,
                     rr_rsp_valid, rr_rsp_data, rr_rsp_id);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (rr_r1_ready !== 1'b1 || rr_r0_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got r0=%b r1=%b want r0=0 r1=1", rr_r0_ready, rr_r1_ready);
      end
      @(posedge clk);
      #1;
      r1_valid = 1'b0;
      checks++;
      if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd7 || rr_rsp_id !== 1'b1) begin
         errors++;
         $display("FAIL bp_nobubble got v=%b data=%h id=%b want v=1 data=7 id=1", rr_rsp_valid,
                  rr_rsp_data, rr_rsp_id);
      end
      tick();
      r0_valid = 1'b0;
      checks++;
      if (rr_rsp_valid !== 1'b1 || rr_rsp_data !== 32'd20 || rr_rsp_id !== 1'b0) begin
         errors++;
         $display("FAIL bp_next got v=%b data=%h id=%b want v=1 data=14 id=0", rr_rsp_valid,
                  rr_rsp_data, rr_rsp_id);
      end
      tick();
      checks++;
      if (rr_rsp_valid !== 1'b0 || rr_rsp_data !== 32'd20) begin
         errors++;
         $display("FAIL bp_drain got v=%b data=%h want v=0 data=14", rr_rsp_valid, rr_rsp_data);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      r0_valid = 1'b1; r0_data = 32'hDEAD_BEEF; r0_shamt = 5'd3; r0_ctrl = 2'b11;
      tick();
      checks++;
      if (rr_rsp_err !== 1'b1 || rr_rsp_data !== 32'h0 || rr_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL illegal got err=%b data=%h v=%b want err=1 data=0 v=1", rr_rsp_err,
                  rr_rsp_data, rr_rsp_valid);
      end
      r0_shamt = 5'd0; r0_ctrl = 2'b10;
      tick();
      r0_valid = 1'b0;
      checks++;
      if (rr_rsp_err !== 1'b0 || rr_rsp_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL shamt0 got err=%b data=%h want err=0 data=deadbeef", rr_rsp_err,
                  rr_rsp_data);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      r0_valid = 1'b1; r0_data = 32'h1; r0_shamt = 5'd0; r0_ctrl = 2'b00;
      rsp_ready = 1'b0;
      tick();
      r1_valid = 1'b1; r1_data = 32'h2; r1_shamt = 5'd0; r1_ctrl = 2'b00;
      rsp_ready = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (rr_r0_ready !== 1'b0 || rr_r1_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_ready got r0=%b r1=%b want 0 0", rr_r0_ready, rr_r1_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rr_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_discard got v=%b want 0", rr_rsp_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rr_r0_ready !== 1'b1 || rr_r1_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_first got r0=%b r1=%b want r0=1 r1=0", rr_r0_ready, rr_r1_ready);
      end
      @(posedge clk);
      #1;
      idle_inputs();
      checks++;
      if (rr_rsp_valid !== 1'b1 || rr_rsp_id !== 1'b0 || rr_rsp_data !== 32'h1) begin
         errors++;
         $display("FAIL rst_first_rsp got v=%b id=%b data=%h want v=1 id=0 data=1",
                  rr_rsp_valid, rr_rsp_id, rr_rsp_data);
      end
   endtask

   // Random traffic obeying the hold-until-ready rule, scored against a slot model.
   task automatic test_random();
      logic        m_valid, m_id, m_err, m_turn;
      logic [31:0] m_data;
      logic        v[2];
      logic [31:0] d[2];
      logic [4:0]  s[2];
      logic [1:0]  c[2];
      logic        free, win, e_rdy0, e_rdy1;
      do_reset();
      m_valid = 1'b0; m_id = 1'b0; m_err = 1'b0; m_data = '0; m_turn = 1'b0;
      for (int n = 0; n < 2; n++) begin
         v[n] = 1'b0; d[n] = '0; s[n] = '0; c[n] = '0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!v[n]) begin
               v[n] = ($urandom_range(0, 9) < 7);
               d[n] = $urandom;
               s[n] = 5'($urandom_range(0, 31));
               c[n] = 2'($urandom_range(0, 3));
            end
         end
         r0_valid = v[0]; r0_data = d[0]; r0_shamt = s[0]; r0_ctrl = c[0];
         r1_valid = v[1]; r1_data = d[1]; r1_shamt = s[1]; r1_ctrl = c[1];
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         free = !m_valid || rsp_ready;
         win = (v[0] && v[1]) ? m_turn : v[1];
         e_rdy0 = free && v[0] && (win == 1'b0);
         e_rdy1 = free && v[1] && (win == 1'b1);
         checks++;
         if (rr_r0_ready !== e_rdy0 || rr_r1_ready !== e_rdy1) begin
            errors++;
            $display("FAIL rand_ready[%0d] got r0=%b r1=%b want r0=%b r1=%b", cyc, rr_r0_ready,
                     rr_r1_ready, e_rdy0, e_rdy1);
         end
         @(posedge clk);
         #1;
         if (e_rdy0 || e_rdy1) begin
            m_valid = 1'b1;
            m_id    = win;
            m_data  = ref_shift(d[win], int'(s[win]), c[win]);
            m_err   = (c[win] == 2'b11);
            m_turn  = ~win;
            v[win]  = 1'b0;
         end else if (rsp_ready) begin
            m_valid = 1'b0;
         end
         checks++;
         if (rr_rsp_valid !== m_valid || (m_valid && (rr_rsp_data !== m_data ||
             rr_rsp_id !== m_id || rr_rsp_err !== m_err))) begin
            errors++;
            $display("FAIL rand_rsp[%0d] got v=%b data=%h id=%b err=%b want v=%b data=%h id=%b err=%b",
                     cyc, rr_rsp_valid, rr_rsp_data, rr_rsp_id, rr_rsp_err, m_valid, m_data,
                     m_id, m_err);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      rsp_ready = 1'b0;
      idle_inputs();
      test_reset();
      test_sll();
      test_sra_srl();
      test_round_robin();
      test_backpressure();
      test_illegal();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
